// File: rtl/j_tmr_pkg.sv
// Shared Jerry timer constants: default widths and CPU read-select encoding.
// The register decode reuses rd_sel_e to drive the rd_lo/rd_hi strobes.
package j_tmr_pkg;

  localparam int CW_DEF = 32;
  localparam int DW_DEF = 16;
  localparam int PW_DEF = 16;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_LO   = 2'b01,
    RD_HI   = 2'b10,
    RD_BOTH = 2'b11
  } rd_sel_e;

endpackage

// File: rtl/j_upcnt.sv
// Single up-count bit cell: toggles when carry-in is high, ripples carry to the next bit.
// Clear beats load, and load beats the toggle.
module j_upcnt (
  input  logic sys_clk,
  input  logic reset,
  input  logic clr,
  input  logic ld,
  input  logic d,
  input  logic ci,
  output logic q,
  output logic co
);

  logic d2;

  assign d2 = ld ? d : (q ^ ci);
  assign co = ci & q;

  always_ff @(posedge sys_clk) begin
    if (reset || clr) begin
      q <= 1'b0;
    end else begin
      q <= d2;
    end
  end

endmodule

// File: rtl/j_upcnt_tmr.sv
// Loadable prescaled up-counter with wrap pulse and coherent two-half CPU read.
// Define J_UPCNT_CMP_EN to build the compare register and sticky cmp_irq.
module j_upcnt_tmr
  import j_tmr_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          run,
  input  logic          tick_en,
  input  logic          pre_ld,
  input  logic [PW-1:0] pre_d,
  input  logic          cnt_clr,
  input  logic          cnt_ld,
  input  logic [CW-1:0] cnt_d,
  input  logic          rd_lo,
  input  logic          rd_hi,
  output logic [DW-1:0] rd_data,
  output logic          ovf,
  input  logic          cmp_ld,
  input  logic [CW-1:0] cmp_d,
  input  logic          cmp_ack,
  output logic          cmp_irq
);

  logic [PW-1:0] preCnt_q, preRld_q;
  logic [DW-1:0] snapHi_q, rdData_q;
  logic          ovf_q;
  logic          preHit, inc;
  logic [CW:0]   carry;
  logic [CW-1:0] cnt, cntInc;
  rd_sel_e       rdSel;

  assign preHit = (preCnt_q == preRld_q);
  assign inc    = tick_en & run & ~pre_ld & preHit;

  // A prescaler reload restarts the divide period and swallows that cycle's tick.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      preCnt_q <= '0;
      preRld_q <= '0;
    end else if (pre_ld) begin
      preRld_q <= pre_d;
      preCnt_q <= '0;
    end else if (tick_en && run) begin
      preCnt_q <= preHit ? '0 : preCnt_q + 1'b1;
    end
  end

  assign carry[0] = inc;

  genvar i;
  generate
    for (i = 0; i < CW; i++) begin : g_bit
      j_upcnt u_bit (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .ld      (cnt_ld),
        .d       (cnt_d[i]),
        .ci      (carry[i]),
        .q       (cnt[i]),
        .co      (carry[i+1])
      );
    end
  endgenerate

  assign cntInc = cnt ^ carry[CW-1:0];

  // Carry out of the top bit is the wrap; a load or clear discards the increment.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= carry[CW] & ~cnt_clr & ~cnt_ld;
    end
  end

  assign rdSel = rd_sel_e'({rd_hi, rd_lo});

  // Low-half read freezes the high half so a following high read is coherent.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      snapHi_q <= '0;
      rdData_q <= '0;
    end else begin
      case (rdSel)
        RD_LO, RD_BOTH: begin
          rdData_q <= cnt[DW-1:0];
          snapHi_q <= cnt[CW-1:DW];
        end
        RD_HI:   rdData_q <= snapHi_q;
        default: rdData_q <= rdData_q;
      endcase
    end
  end

  assign rd_data = rdData_q;
  assign ovf     = ovf_q;

`ifdef J_UPCNT_CMP_EN
  logic [CW-1:0] cmpVal_q;
  logic          cmpIrq_q;
  logic          cmpHit;

  assign cmpHit = inc & ~cnt_clr & ~cnt_ld & (cntInc == cmpVal_q);

  // A new match wins over a simultaneous acknowledge.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cmpVal_q <= '0;
      cmpIrq_q <= 1'b0;
    end else begin
      if (cmp_ld) begin
        cmpVal_q <= cmp_d;
      end
      if (cmpHit) begin
        cmpIrq_q <= 1'b1;
      end else if (cmp_ack) begin
        cmpIrq_q <= 1'b0;
      end
    end
  end

  assign cmp_irq = cmpIrq_q;
`else
  logic unusedCmp;

  assign unusedCmp = ^{cmp_ld, cmp_d, cmp_ack, cntInc};
  assign cmp_irq   = 1'b0;
`endif

endmodule
